// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller for the core clock enable.
// Host commands, PC breakpoints and break instructions decide which cycles the core may advance.
module cpu_run_ctrl #(
    parameter int ADDR_W = 32,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic              halt_instr,
    output logic              cpu_ce,
    output logic [1:0]        run_state,
    output logic [2:0]        halt_cause,
    output logic              step_done,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_t;

    localparam logic [2:0] CAUSE_RESET = 3'd0;
    localparam logic [2:0] CAUSE_HOST  = 3'd1;
    localparam logic [2:0] CAUSE_BP    = 3'd2;
    localparam logic [2:0] CAUSE_INSTR = 3'd3;
    localparam logic [2:0] CAUSE_STEP  = 3'd4;

    state_t            state;
    logic [STEP_W-1:0] steps_left;
    logic              bp_skip;
    logic              bp_hit;
    logic              active;
    logic              resume_skip;

    // run_state is the FSM state itself, so checkers can bind to it directly.
    assign run_state = state;

    assign bp_hit      = bp_en && (pc == bp_addr) && !bp_skip;
    assign active      = (state == RUN) || (state == STEP);
    assign cpu_ce      = !reset && active && !bp_hit;
    assign resume_skip = (halt_cause == CAUSE_BP);

    // Commands are single-cycle pulses with no back-pressure: a pulse is
    // consumed at the edge it is seen, priority halt > run > step, and
    // cpu_ce reflects the new state from the following cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HALT;
            halt_cause  <= CAUSE_RESET;
            step_done   <= 1'b0;
            cycle_count <= '0;
            steps_left  <= '0;
            bp_skip     <= 1'b0;
        end else begin
            step_done <= 1'b0;

            if (cpu_ce) begin
                cycle_count <= cycle_count + CNT_W'(1);
                bp_skip     <= 1'b0;
            end

            case (state)
                HALT: begin
                    if (!halt_req) begin
                        if (run_req) begin
                            state   <= RUN;
                            bp_skip <= resume_skip;
                        end else if (step_req && (step_count != '0)) begin
                            state      <= STEP;
                            steps_left <= step_count;
                            bp_skip    <= resume_skip;
                        end
                    end
                end

                RUN: begin
                    if (halt_req) begin
                        state      <= HALT;
                        halt_cause <= CAUSE_HOST;
                    end else if (bp_hit) begin
                        state      <= HALT;
                        halt_cause <= CAUSE_BP;
                    end else if (halt_instr && cpu_ce) begin
                        state      <= HALT;
                        halt_cause <= CAUSE_INSTR;
                    end
                end

                STEP: begin
                    if (halt_req) begin
                        state      <= HALT;
                        halt_cause <= CAUSE_HOST;
                        steps_left <= '0;
                    end else if (run_req) begin
                        state      <= RUN;
                        steps_left <= '0;
                    end else if (bp_hit) begin
                        state      <= HALT;
                        halt_cause <= CAUSE_BP;
                        steps_left <= '0;
                    end else if (cpu_ce) begin
                        steps_left <= steps_left - STEP_W'(1);
                        // A break instruction on the final step still completes the sequence.
                        if (steps_left == STEP_W'(1)) begin
                            state      <= HALT;
                            step_done  <= 1'b1;
                            halt_cause <= halt_instr ? CAUSE_INSTR : CAUSE_STEP;
                        end else if (halt_instr) begin
                            state      <= HALT;
                            halt_cause <= CAUSE_INSTR;
                            steps_left <= '0;
                        end
                    end
                end

                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a 32-bit counter instance plus a 4-bit
// counter instance sharing the same stimulus for the wrap check.
module tb_cpu_run_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic [15:0] step_count;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        halt_instr;

  logic        cpu_ce;
  logic [1:0]  run_state;
  logic [2:0]  halt_cause;
  logic        step_done;
  logic [31:0] cycle_count;

  logic        w_cpu_ce;
  logic [1:0]  w_run_state;
  logic [2:0]  w_halt_cause;
  logic        w_step_done;
  logic [3:0]  w_cycle_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] ce_pat;
  logic [7:0] sd_pat;
  int done_seen;

  // clock / reset
  always #5 clock = ~clock;

  cpu_run_ctrl #(.ADDR_W(32), .STEP_W(16), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .halt_instr(halt_instr), .cpu_ce(cpu_ce), .run_state(run_state),
    .halt_cause(halt_cause), .step_done(step_done), .cycle_count(cycle_count)
  );

  cpu_run_ctrl #(.ADDR_W(32), .STEP_W(16), .CNT_W(4)) dut_w (
    .clock(clock), .reset(reset), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .halt_instr(halt_instr), .cpu_ce(w_cpu_ce), .run_state(w_run_state),
    .halt_cause(w_halt_cause), .step_done(w_step_done), .cycle_count(w_cycle_count)
  );

  // driver tasks
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_run();
    run_req = 1'b1;
    cycle();
    run_req = 1'b0;
  endtask

  task automatic pulse_halt();
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
  endtask

  task automatic pulse_step(input logic [15:0] n);
    step_count = n;
    step_req   = 1'b1;
    cycle();
    step_req   = 1'b0;
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    step_count = '0; bp_en = 1'b0; bp_addr = '0; pc = 32'h0040_0000; halt_instr = 1'b0;

    // reset held 3 cycles
    repeat (3) cycle();
    chk("ce_in_reset", 32'(cpu_ce), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(run_state), 32'd0);
    chk("rst_ce", 32'(cpu_ce), 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_cause", 32'(halt_cause), 32'd0);
    chk("rst_done", 32'(step_done), 32'd0);
    pulse_halt();
    chk("halt_in_halt_state", 32'(run_state), 32'd0);
    chk("halt_in_halt_cause", 32'(halt_cause), 32'd0);
    chk("halt_in_halt_count", cycle_count, 32'd0);

    // step 5
    pulse_step(16'd5);
    for (int i = 0; i < 8; i++) begin
      ce_pat[i] = cpu_ce;
      sd_pat[i] = step_done;
      cycle();
    end
    chk("step5_ce_pattern", 32'(ce_pat), 32'h1F);
    chk("step5_done_pattern", 32'(sd_pat), 32'h20);
    chk("step5_state", 32'(run_state), 32'd0);
    chk("step5_cause", 32'(halt_cause), 32'd4);
    chk("step5_count", cycle_count, 32'd5);

    // breakpoint in RUN
    bp_en = 1'b1;
    bp_addr = 32'h0040_0010;
    pulse_run();
    for (int i = 0; i < 4; i++) begin
      pc = 32'h0040_0000 + 32'(4 * i);
      #1;
      chk("bp_pre_ce", 32'(cpu_ce), 32'd1);
      cycle();
    end
    pc = 32'h0040_0010;
    #1;
    chk("bp_hit_ce", 32'(cpu_ce), 32'd0);
    cycle();
    chk("bp_state", 32'(run_state), 32'd0);
    chk("bp_cause", 32'(halt_cause), 32'd2);
    chk("bp_count", cycle_count, 32'd9);
    pulse_run();
    chk("bp_resume_ce", 32'(cpu_ce), 32'd1);
    cycle();
    chk("bp_resume_count", cycle_count, 32'd10);
    pc = 32'h0040_0014;
    #1;
    chk("bp_next_ce", 32'(cpu_ce), 32'd1);
    cycle();
    chk("bp_run_state", 32'(run_state), 32'd1);
    pulse_halt();
    chk("host_halt_state", 32'(run_state), 32'd0);
    chk("host_halt_cause", 32'(halt_cause), 32'd1);
    chk("host_halt_count", cycle_count, 32'd12);
    bp_en = 1'b0;

    // halt instruction on cycle 7
    pulse_run();
    for (int i = 1; i <= 7; i++) begin
      halt_instr = (i == 7);
      cycle();
    end
    halt_instr = 1'b0;
    chk("instr_state", 32'(run_state), 32'd0);
    chk("instr_cause", 32'(halt_cause), 32'd3);
    chk("instr_count", cycle_count, 32'd19);
    pulse_run();
    halt_instr = 1'b1;
    halt_req = 1'b1;
    cycle();
    halt_instr = 1'b0;
    halt_req = 1'b0;
    chk("instr_vs_host_cause", 32'(halt_cause), 32'd1);
    chk("instr_vs_host_count", cycle_count, 32'd20);

    // step 10 interrupted after 4 enabled cycles
    done_seen = 0;
    pulse_step(16'd10);
    for (int i = 0; i < 3; i++) begin
      done_seen += int'(step_done);
      cycle();
    end
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done_seen += int'(step_done);
      cycle();
    end
    chk("step_abort_state", 32'(run_state), 32'd0);
    chk("step_abort_cause", 32'(halt_cause), 32'd1);
    chk("step_abort_count", cycle_count, 32'd24);
    chk("step_abort_no_done", 32'(done_seen), 32'd0);

    // step_count 0 is ignored
    pulse_step(16'd0);
    chk("step0_state", 32'(run_state), 32'd0);
    chk("step0_ce", 32'(cpu_ce), 32'd0);
    chk("step0_count", cycle_count, 32'd24);

    // run and step together
    step_count = 16'd3;
    run_req = 1'b1;
    step_req = 1'b1;
    cycle();
    run_req = 1'b0;
    step_req = 1'b0;
    chk("run_step_state", 32'(run_state), 32'd1);
    chk("run_step_ce", 32'(cpu_ce), 32'd1);
    pulse_halt();
    chk("run_step_count", cycle_count, 32'd25);

    // reset mid-STEP with 3 steps left
    pulse_step(16'd5);
    cycle();
    cycle();
    chk("mid_step_ce", 32'(cpu_ce), 32'd1);
    chk("mid_step_count", cycle_count, 32'd27);
    reset = 1'b1;
    #1;
    chk("reset_cycle_ce", 32'(cpu_ce), 32'd0);
    cycle();
    reset = 1'b0;
    #1;
    chk("mid_reset_state", 32'(run_state), 32'd0);
    chk("mid_reset_count", cycle_count, 32'd0);
    chk("mid_reset_cause", 32'(halt_cause), 32'd0);
    chk("mid_reset_done", 32'(step_done), 32'd0);
    cycle();
    chk("post_reset_state", 32'(run_state), 32'd0);
    chk("post_reset_done", 32'(step_done), 32'd0);
    chk("post_reset_count", cycle_count, 32'd0);

    // 4-bit counter wrap after 16 enabled cycles
    pulse_run();
    repeat (15) cycle();
    chk("wrap_w_15", 32'(w_cycle_count), 32'd15);
    pulse_halt();
    chk("wrap_w_0", 32'(w_cycle_count), 32'd0);
    chk("wrap_main_16", cycle_count, 32'd16);

    // halt instruction on the last step
    pulse_step(16'd2);
    cycle();
    halt_instr = 1'b1;
    cycle();
    halt_instr = 1'b0;
    chk("last_step_instr_done", 32'(step_done), 32'd1);
    chk("last_step_instr_cause", 32'(halt_cause), 32'd3);
    chk("last_step_instr_state", 32'(run_state), 32'd0);
    chk("last_step_instr_count", cycle_count, 32'd18);
    cycle();
    chk("last_step_done_clear", 32'(step_done), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
